bus_sequencer: RTL and testbench

//   Execute-phase control sequencer for the shared 32-bit datapath bus.

---
 rtl/bus_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_bus_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sequencer.sv
// Execute-phase bus sequencer: steps one accepted command through T3..T6
// and drives registered, one-hot bus source and sink strobes each cycle.
module bus_sequencer #(
   parameter int MULDIV_CYCLES = 1,
   parameter int ALU_OP_W      = 5
) (
   input  logic                clock,
   input  logic                clear,
   input  logic                start,
   input  logic [1:0]          cmd_class,
   input  logic [ALU_OP_W-1:0] alu_op_in,
   input  logic [3:0]          ra,
   input  logic [3:0]          rb,
   input  logic [3:0]          rc,
   output logic                busy,
   output logic                done,
   output logic [15:0]         r_out,
   output logic [15:0]         r_in,
   output logic                hiout,
   output logic                loout,
   output logic                zhighout,
   output logic                zlowout,
   output logic                cout,
   output logic                in_portout,
   output logic                yin,
   output logic                zin,
   output logic                hiin,
   output logic                loin,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [2:0]          state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T3   = 3'd1,
      S_T4   = 3'd2,
      S_T5   = 3'd3,
      S_T6   = 3'd4,
      S_DONE = 3'd5
   } state_t;

   localparam logic [1:0] C_REG = 2'd0;
   localparam logic [1:0] C_IMM = 2'd1;
   localparam logic [1:0] C_MD  = 2'd2;
   localparam logic [1:0] C_IN  = 2'd3;

   localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

   state_t              state_q, state_d;
   logic [1:0]          cls_q, cls_d;
   logic [ALU_OP_W-1:0] op_q, op_d;
   logic [3:0]          ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                busy_d, done_d, zhighout_d, zlowout_d, cout_d, in_portout_d;
   logic                yin_d, zin_d, hiin_d, loin_d;
   logic [15:0]         r_out_d, r_in_d;
   logic [ALU_OP_W-1:0] alu_op_d;

   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      op_d    = op_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      rc_d    = rc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               cls_d   = cmd_class;
               op_d    = alu_op_in;
               ra_d    = ra;
               rb_d    = rb;
               rc_d    = rc;
               state_d = (cmd_class == C_IN) ? S_T5 : S_T3;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_T3: begin
            state_d = S_T4;
            cnt_d   = CNT_LOAD;
         end
         // mul/div dwells in T4 while the counter drains; other classes pass through
         S_T4: begin
            if (cls_q == C_MD && cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = S_T5;
            end
         end
         S_T5:    state_d = (cls_q == C_MD) ? S_T6 : S_DONE;
         S_T6:    state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes are decoded from the next state so they register alongside it.
   always_comb begin
      busy_d       = 1'b0;
      done_d       = 1'b0;
      r_out_d      = '0;
      r_in_d       = '0;
      zhighout_d   = 1'b0;
      zlowout_d    = 1'b0;
      cout_d       = 1'b0;
      in_portout_d = 1'b0;
      yin_d        = 1'b0;
      zin_d        = 1'b0;
      hiin_d       = 1'b0;
      loin_d       = 1'b0;
      alu_op_d     = '0;
      unique case (state_d)
         S_T3: begin
            busy_d  = 1'b1;
            yin_d   = 1'b1;
            r_out_d = 16'(1) << ((cls_d == C_MD) ? ra_d : rb_d);
         end
         S_T4: begin
            busy_d   = 1'b1;
            zin_d    = 1'b1;
            alu_op_d = op_d;
            unique case (cls_d)
               C_IMM:   cout_d  = 1'b1;
               C_MD:    r_out_d = 16'(1) << rb_d;
               default: r_out_d = 16'(1) << rc_d;
            endcase
         end
         S_T5: begin
            busy_d = 1'b1;
            if (cls_d == C_IN) begin
               in_portout_d = 1'b1;
               r_in_d       = 16'(1) << ra_d;
            end else if (cls_d == C_MD) begin
               zlowout_d = 1'b1;
               loin_d    = 1'b1;
            end else begin
               zlowout_d = 1'b1;
               r_in_d    = 16'(1) << ra_d;
            end
         end
         S_T6: begin
            busy_d     = 1'b1;
            zhighout_d = 1'b1;
            hiin_d     = 1'b1;
         end
         S_DONE:  done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q    <= S_IDLE;
         cls_q      <= C_REG;
         op_q       <= '0;
         ra_q       <= '0;
         rb_q       <= '0;
         rc_q       <= '0;
         cnt_q      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         r_out      <= '0;
         r_in       <= '0;
         zhighout   <= 1'b0;
         zlowout    <= 1'b0;
         cout       <= 1'b0;
         in_portout <= 1'b0;
         yin        <= 1'b0;
         zin        <= 1'b0;
         hiin       <= 1'b0;
         loin       <= 1'b0;
         alu_op     <= '0;
      end else begin
         state_q    <= state_d;
         cls_q      <= cls_d;
         op_q       <= op_d;
         ra_q       <= ra_d;
         rb_q       <= rb_d;
         rc_q       <= rc_d;
         cnt_q      <= cnt_d;
         busy       <= busy_d;
         done       <= done_d;
         r_out      <= r_out_d;
         r_in       <= r_in_d;
         zhighout   <= zhighout_d;
         zlowout    <= zlowout_d;
         cout       <= cout_d;
         in_portout <= in_portout_d;
         yin        <= yin_d;
         zin        <= zin_d;
         hiin       <= hiin_d;
         loin       <= loin_d;
         alu_op     <= alu_op_d;
      end
   end

   // No command in this set reads HI or LO back onto the bus.
   assign hiout     = 1'b0;
   assign loout     = 1'b0;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: directed vector table, async reset mid-command,
// and randomized commands checked against a transfer-level model.
module tb_bus_sequencer;

   localparam int MD = 3;
   localparam int W  = 49;

   localparam logic [5:0] SRC_ZH = 6'b001000;
   localparam logic [5:0] SRC_ZL = 6'b000100;
   localparam logic [5:0] SRC_C  = 6'b000010;
   localparam logic [5:0] SRC_IN = 6'b000001;
   localparam logic [3:0] SNK_Y  = 4'b1000;
   localparam logic [3:0] SNK_Z  = 4'b0100;
   localparam logic [3:0] SNK_HI = 4'b0010;
   localparam logic [3:0] SNK_LO = 4'b0001;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  cmd_class = '0;
   logic [4:0]  alu_op_in = '0;
   logic [3:0]  ra = '0, rb = '0, rc = '0;
   logic        busy, done, hiout, loout, zhighout, zlowout, cout, in_portout;
   logic        yin, zin, hiin, loin;
   logic [15:0] r_out, r_in;
   logic [4:0]  alu_op;
   logic [2:0]  state_dbg;
   logic [W-1:0] obs;

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   bus_sequencer #(.MULDIV_CYCLES(MD), .ALU_OP_W(5)) dut (
      .clock(clock), .clear(clear), .start(start), .cmd_class(cmd_class),
      .alu_op_in(alu_op_in), .ra(ra), .rb(rb), .rc(rc),
      .busy(busy), .done(done), .r_out(r_out), .r_in(r_in),
      .hiout(hiout), .loout(loout), .zhighout(zhighout), .zlowout(zlowout),
      .cout(cout), .in_portout(in_portout), .yin(yin), .zin(zin),
      .hiin(hiin), .loin(loin), .alu_op(alu_op), .state_dbg(state_dbg)
   );

   assign obs = {busy, done, r_out, r_in, hiout, loout, zhighout, zlowout,
                 cout, in_portout, yin, zin, hiin, loin, alu_op};

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   // ---------------- scoreboard / model ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_exp = '0;
   int total = 0;
   int bad   = 0;

   function automatic logic [W-1:0] mk(input logic b, input logic d,
                                       input logic [15:0] ro, input logic [15:0] ri,
                                       input logic [5:0] src, input logic [3:0] snk,
                                       input logic [4:0] op);
      return {b, d, ro, ri, src, snk, op};
   endfunction

   function automatic logic [15:0] bit16(input logic [3:0] n);
      return 16'(1) << n;
   endfunction

   // One entry per bus cycle of the command, ending with the done cycle.
   task automatic push_cmd(input logic [1:0] c, input logic [4:0] o,
                           input logic [3:0] a, input logic [3:0] b, input logic [3:0] cc);
      case (c)
         2'd0, 2'd1: begin
            exp_q.push_back(mk(1'b1, 1'b0, bit16(b), '0, '0, SNK_Y, '0));
            if (c == 2'd0) exp_q.push_back(mk(1'b1, 1'b0, bit16(cc), '0, '0, SNK_Z, o));
            else           exp_q.push_back(mk(1'b1, 1'b0, '0, '0, SRC_C, SNK_Z, o));
            exp_q.push_back(mk(1'b1, 1'b0, '0, bit16(a), SRC_ZL, '0, '0));
         end
         2'd2: begin
            exp_q.push_back(mk(1'b1, 1'b0, bit16(a), '0, '0, SNK_Y, '0));
            for (int k = 0; k < MD; k++)
               exp_q.push_back(mk(1'b1, 1'b0, bit16(b), '0, '0, SNK_Z, o));
            exp_q.push_back(mk(1'b1, 1'b0, '0, '0, SRC_ZL, SNK_LO, '0));
            exp_q.push_back(mk(1'b1, 1'b0, '0, '0, SRC_ZH, SNK_HI, '0));
         end
         default: exp_q.push_back(mk(1'b1, 1'b0, '0, bit16(a), SRC_IN, '0, '0));
      endcase
      exp_q.push_back(mk(1'b0, 1'b1, '0, '0, '0, '0, '0));
   endtask

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_inv();
      int srcs;
      srcs = $countones(r_out) +
             $countones({hiout, loout, zhighout, zlowout, cout, in_portout});
      total++;
      if (srcs > 1 || (!busy && srcs != 0) || !$onehot0(r_in)) begin
         bad++;
         $display("FAIL invariant: got sources=%0d r_in=%h busy=%b want sources<=1 onehot0 r_in",
                  srcs, r_in, busy);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic s, input logic [1:0] c, input logic [4:0] o,
                        input logic [3:0] a, input logic [3:0] b, input logic [3:0] cc);
      start     = s;
      cmd_class = c;
      alu_op_in = o;
      ra        = a;
      rb        = b;
      rc        = cc;
      if (s && !last_exp[W-1]) push_cmd(c, o, a, b, cc);
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) last_exp = exp_q.pop_front();
      else                  last_exp = '0;
   endtask

   typedef struct {
      logic         s;
      logic [1:0]   c;
      logic [4:0]   o;
      logic [3:0]   a, b, cc;
      logic [W-1:0] e;
   } vec_t;

   vec_t tbl[24];

   initial begin
      logic [W-1:0] done_v;
      logic         s;
      logic [1:0]   c;
      logic [4:0]   o;
      logic [3:0]   a, b, cc;
      int           issued, cycles;

      done_v = mk(1'b0, 1'b1, '0, '0, '0, '0, '0);
      // reg-reg ra=3 rb=5 rc=7 op=03
      tbl[0]  = '{1'b1, 2'd0, 5'h03, 4'd3, 4'd5, 4'd7, mk(1'b1, 1'b0, 16'h0020, '0, '0, SNK_Y, '0)};
      tbl[1]  = '{1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0, mk(1'b1, 1'b0, 16'h0080, '0, '0, SNK_Z, 5'h03)};
      tbl[2]  = '{1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0, mk(1'b1, 1'b0, '0, 16'h0008, SRC_ZL, '0, '0)};
      tbl[3]  = '{1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0, done_v};
      tbl[4]  = '{1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0, '0};
      // reg-imm ra=2 rb=4 op=11
      tbl[5]  = '{1'b1, 2'd1, 5'h11, 4'd2, 4'd4, 4'd6, mk(1'b1, 1'b0, 16'h0010, '0, '0, SNK_Y, '0)};
      tbl[6]  = '{1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0, mk(1'b1, 1'b0, '0, '0, SRC_C, SNK_Z, 5'h11)};
      tbl[7]  = '{1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0, mk(1'b1, 1'b0, '0, 16'h0004, SRC_ZL, '0, '0)};
      tbl[8]  = '{1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0, done_v};
      // in_port ra=9, start held through DONE into a reg-reg; starts while busy ignored
      tbl[9]  = '{1'b1, 2'd3, 5'h00, 4'd9, 4'd0, 4'd0, mk(1'b1, 1'b0, '0, 16'h0200, SRC_IN, '0, '0)};
      tbl[10] = '{1'b1, 2'd2, 5'h1f, 4'd14, 4'd13, 4'd12, done_v};
      tbl[11] = '{1'b1, 2'd0, 5'h0a, 4'd1, 4'd2, 4'd3, mk(1'b1, 1'b0, 16'h0004, '0, '0, SNK_Y, '0)};
      tbl[12] = '{1'b1, 2'd1, 5'h1f, 4'd15, 4'd14, 4'd13, mk(1'b1, 1'b0, 16'h0008, '0, '0, SNK_Z, 5'h0a)};
      tbl[13] = '{1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0, mk(1'b1, 1'b0, '0, 16'h0002, SRC_ZL, '0, '0)};
      tbl[14] = '{1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0, done_v};
      tbl[15] = '{1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0, '0};
      // mul/div ra=1 rb=2 op=07, three T4 cycles
      tbl[16] = '{1'b1, 2'd2, 5'h07, 4'd1, 4'd2, 4'd0, mk(1'b1, 1'b0, 16'h0002, '0, '0, SNK_Y, '0)};
      tbl[17] = '{1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0, mk(1'b1, 1'b0, 16'h0004, '0, '0, SNK_Z, 5'h07)};
      tbl[18] = '{1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0, mk(1'b1, 1'b0, 16'h0004, '0, '0, SNK_Z, 5'h07)};
      tbl[19] = '{1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0, mk(1'b1, 1'b0, 16'h0004, '0, '0, SNK_Z, 5'h07)};
      tbl[20] = '{1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0, mk(1'b1, 1'b0, '0, '0, SRC_ZL, SNK_LO, '0)};
      tbl[21] = '{1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0, mk(1'b1, 1'b0, '0, '0, SRC_ZH, SNK_HI, '0)};
      tbl[22] = '{1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0, done_v};
      tbl[23] = '{1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0, '0};

      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_state", obs, '0);
      clear = 1'b1;

      for (int i = 0; i < 24; i++) begin
         drive(tbl[i].s, tbl[i].c, tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].cc);
         check($sformatf("vec%0d", i), obs, tbl[i].e);
         check_inv();
      end

      // clear asserted while a mul/div sits in T4
      drive(1'b1, 2'd2, 5'h15, 4'd4, 4'd5, 4'd0);
      drive(1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0);
      check("md_in_t4", obs, mk(1'b1, 1'b0, bit16(4'd5), '0, '0, SNK_Z, 5'h15));
      #2;
      clear = 1'b0;
      #1;
      check("reset_async", obs, '0);
      @(negedge clock);
      clear = 1'b1;
      exp_q.delete();
      last_exp = '0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0);
         check("post_reset_idle", obs, '0);
      end

      // randomized commands against the model
      issued = 0;
      cycles = 0;
      while (issued < 1000 && cycles < 20000) begin
         s  = ($urandom_range(0, 3) != 0);
         c  = 2'($urandom_range(0, 3));
         o  = 5'($urandom_range(0, 31));
         a  = 4'($urandom_range(0, 15));
         b  = 4'($urandom_range(0, 15));
         cc = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) begin
            b  = a;
            cc = a;
         end
         if (s && !last_exp[W-1]) issued++;
         drive(s, c, o, a, b, cc);
         check("random", obs, last_exp);
         check_inv();
         cycles++;
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 2'd0, 5'h00, 4'd0, 4'd0, 4'd0);
         check("drain", obs, last_exp);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
